// File: rtl/mt_state_ctrl_pkg.sv
// mt_state_ctrl_pkg: shared thread state, instruction type and done-instruction encoding
package mt_state_ctrl_pkg;
  typedef enum logic [2:0] {IDLE = 3'd0, RUN = 3'd1, STEP = 3'd2, ERR = 3'd3} state_e;
  typedef struct packed {
    logic [7:0]  opcode;
    logic [23:0] operand;
  } instruction_s;
  localparam instruction_s kDONE = '{opcode: 8'hFF, operand: 24'h0};
  function automatic logic is_done(input instruction_s ins);
    return ins == kDONE;
  endfunction
endpackage

// File: rtl/mt_state_thread.sv
// mt_state_thread: one hardware thread's IDLE/RUN/STEP/ERR FSM with single-step budget
module mt_state_thread
  import mt_state_ctrl_pkg::*;
#(
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              retire_i,
  input  logic              done_i,
  input  logic              exc_i,
  input  logic              start_i,
  input  logic              step_i,
  input  logic              clear_i,
  input  logic [STEP_W-1:0] step_cnt_i,
  output state_e            state_o,
  output state_e            state_nxt_o
);
  state_e            state_q, state_d;
  logic [STEP_W-1:0] cnt_q, cnt_d;
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // an exception outranks both a done instruction and budget expiry
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = RUN;
        else if (step_i && step_cnt_i != '0) begin
          state_d = STEP;
          cnt_d   = step_cnt_i;
        end
      end
      RUN: if (retire_i) state_d = exc_i ? ERR : done_i ? IDLE : RUN;
      STEP: begin
        if (retire_i) begin
          state_d = exc_i ? ERR : (done_i || cnt_q == STEP_W'(1)) ? IDLE : STEP;
          cnt_d   = (exc_i || done_i || cnt_q == STEP_W'(1)) ? '0 : cnt_q - 1'b1;
        end
      end
      ERR: if (clear_i) state_d = IDLE;
      default: begin
        state_d = ERR;
        cnt_d   = '0;
      end
    endcase
  end
  assign state_o     = state_q;
  assign state_nxt_o = state_d;
endmodule

// File: rtl/mt_state_ctrl.sv
// mt_state_ctrl: per-thread run/step/error control with first-error latch
module mt_state_ctrl
  import mt_state_ctrl_pkg::*;
#(
  parameter  int THREADS = 2,
  parameter  int STEP_W  = 8,
  localparam int TW      = THREADS > 1 ? $clog2(THREADS) : 1
) (
  input  logic                       clk,
  input  logic                       n_reset,
  input  instruction_s               instruction_i,
  input  logic [TW-1:0]              thread_sel_i,
  input  logic                       stall_i,
  input  logic                       exception_i,
  input  logic                       net_start_i,
  input  logic                       net_step_i,
  input  logic                       net_clear_i,
  input  logic [TW-1:0]              net_tid_i,
  input  logic [STEP_W-1:0]          net_step_cnt_i,
  output state_e [THREADS-1:0]       state_o,
  output logic                       any_run_o,
  output logic                       err_valid_o,
  output logic [TW-1:0]              err_tid_o
);
  logic [THREADS-1:0] hit_net, hit_ret, run_v, err_v, enter_v;
  state_e [THREADS-1:0] nxt;
  logic          done;
  logic          any_run_q, err_valid_q;
  logic [TW-1:0] err_tid_q, err_tid_d, first_tid;
  assign done = is_done(instruction_i);
  for (genvar t = 0; t < THREADS; t++) begin : g_thr
    assign hit_net[t] = net_tid_i == TW'(t);
    assign hit_ret[t] = ~stall_i & (thread_sel_i == TW'(t));
    assign run_v[t]   = nxt[t] == RUN || nxt[t] == STEP;
    assign err_v[t]   = nxt[t] == ERR;
    assign enter_v[t] = err_v[t] & (state_o[t] != ERR);
    mt_state_thread #(.STEP_W(STEP_W)) u_thr (
      .clk        (clk),
      .n_reset    (n_reset),
      .retire_i   (hit_ret[t]),
      .done_i     (done),
      .exc_i      (exception_i),
      .start_i    (net_start_i & hit_net[t]),
      .step_i     (net_step_i & hit_net[t]),
      .clear_i    (net_clear_i & hit_net[t]),
      .step_cnt_i (net_step_cnt_i),
      .state_o    (state_o[t]),
      .state_nxt_o(nxt[t])
    );
  end
  // descending scan leaves the lowest entering id
  always_comb begin
    first_tid = '0;
    for (int i = THREADS - 1; i >= 0; i--) if (enter_v[i]) first_tid = TW'(i);
  end
  assign err_tid_d = (!err_valid_q && |enter_v) ? first_tid : err_tid_q;
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      any_run_q   <= 1'b0;
      err_valid_q <= 1'b0;
      err_tid_q   <= '0;
    end else begin
      any_run_q   <= |run_v;
      err_valid_q <= |err_v;
      err_tid_q   <= err_tid_d;
    end
  end
  assign any_run_o   = any_run_q;
  assign err_valid_o = err_valid_q;
  assign err_tid_o   = err_tid_q;
endmodule

// File: tb/tb_mt_state_ctrl.sv
// tb_mt_state_ctrl: directed scenarios plus randomized traffic against a thread-level model
module tb_mt_state_ctrl;
  import mt_state_ctrl_pkg::*;
  localparam int THREADS = 2;
  localparam int STEP_W = 8;
  localparam int TW = 1;
  logic clk = 1'b0;
  logic n_reset = 1'b0;
  instruction_s instruction_i;
  logic [TW-1:0] thread_sel_i, net_tid_i, err_tid_o;
  logic stall_i, exception_i, net_start_i, net_step_i, net_clear_i, any_run_o, err_valid_o;
  logic [STEP_W-1:0] net_step_cnt_i;
  state_e [THREADS-1:0] state_o;
  int n_checks = 0;
  int n_fail = 0;
  state_e m_st[THREADS];
  int m_bud[THREADS];
  bit m_ev, m_run;
  int m_etid;
  localparam instruction_s PLAIN = '{opcode: 8'h01, operand: 24'h00ABCD};

  mt_state_ctrl #(.THREADS(THREADS), .STEP_W(STEP_W)) dut (
    .clk(clk), .n_reset(n_reset), .instruction_i(instruction_i), .thread_sel_i(thread_sel_i),
    .stall_i(stall_i), .exception_i(exception_i), .net_start_i(net_start_i), .net_step_i(net_step_i),
    .net_clear_i(net_clear_i), .net_tid_i(net_tid_i), .net_step_cnt_i(net_step_cnt_i),
    .state_o(state_o), .any_run_o(any_run_o), .err_valid_o(err_valid_o), .err_tid_o(err_tid_o)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    stall_i = 1'b1; exception_i = 1'b0; instruction_i = PLAIN; thread_sel_i = '0;
    net_start_i = 1'b0; net_step_i = 1'b0; net_clear_i = 1'b0; net_tid_i = '0; net_step_cnt_i = '0;
  endtask

  task automatic model_reset();
    for (int t = 0; t < THREADS; t++) begin m_st[t] = IDLE; m_bud[t] = 0; end
    m_ev = 0; m_etid = 0; m_run = 0;
  endtask

  task automatic model_step();
    state_e prev;
    bit addr, ret, done;
    int lowest;
    lowest = -1;
    done = (instruction_i == kDONE);
    for (int t = 0; t < THREADS; t++) begin
      prev = m_st[t];
      addr = (int'(net_tid_i) == t);
      ret = !stall_i && (int'(thread_sel_i) == t);
      if (prev == IDLE) begin
        if (net_start_i && addr) m_st[t] = RUN;
        else if (net_step_i && addr && net_step_cnt_i != 0) begin m_st[t] = STEP; m_bud[t] = int'(net_step_cnt_i); end
      end else if (prev == ERR) begin
        if (net_clear_i && addr) m_st[t] = IDLE;
      end else if (ret) begin
        if (exception_i) begin m_st[t] = ERR; m_bud[t] = 0; end
        else if (prev == RUN) begin if (done) m_st[t] = IDLE; end
        else begin
          m_bud[t] = m_bud[t] - 1;
          if (done || m_bud[t] == 0) begin m_st[t] = IDLE; m_bud[t] = 0; end
        end
      end
      if (m_st[t] == ERR && prev != ERR && lowest < 0) lowest = t;
    end
    if (!m_ev && lowest >= 0) m_etid = lowest;
    m_ev = 0; m_run = 0;
    for (int t = 0; t < THREADS; t++) begin
      if (m_st[t] == ERR) m_ev = 1;
      if (m_st[t] == RUN || m_st[t] == STEP) m_run = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    n_reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    n_checks++; if (state_o[0] !== IDLE) begin n_fail++; $display("FAIL reset_st0: got %0d want %0d", state_o[0], IDLE); end
    n_checks++; if (state_o[1] !== IDLE) begin n_fail++; $display("FAIL reset_st1: got %0d want %0d", state_o[1], IDLE); end
    n_checks++; if (any_run_o !== 1'b0) begin n_fail++; $display("FAIL reset_any_run: got %b want 0", any_run_o); end
    n_checks++; if (err_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_err_valid: got %b want 0", err_valid_o); end
    n_checks++; if (err_tid_o !== '0) begin n_fail++; $display("FAIL reset_err_tid: got %0d want 0", err_tid_o); end
    n_reset = 1'b1;
  endtask

  task automatic test_start();
    net_start_i = 1; net_tid_i = 1; tick();
    n_checks++; if (state_o[1] !== RUN) begin n_fail++; $display("FAIL start_st1: got %0d want %0d", state_o[1], RUN); end
    n_checks++; if (state_o[0] !== IDLE) begin n_fail++; $display("FAIL start_st0: got %0d want %0d", state_o[0], IDLE); end
    n_checks++; if (any_run_o !== 1'b1) begin n_fail++; $display("FAIL start_any_run: got %b want 1", any_run_o); end
    stall_i = 0; thread_sel_i = 1; instruction_i = kDONE; tick();
    n_checks++; if (state_o[1] !== IDLE) begin n_fail++; $display("FAIL run_done_st1: got %0d want %0d", state_o[1], IDLE); end
    n_checks++; if (any_run_o !== 1'b0) begin n_fail++; $display("FAIL run_done_any_run: got %b want 0", any_run_o); end
  endtask

  task automatic test_step();
    state_e want[6] = '{STEP, STEP, STEP, STEP, STEP, IDLE};
    net_step_i = 1; net_tid_i = 0; net_step_cnt_i = 3; tick();
    n_checks++; if (state_o[0] !== STEP) begin n_fail++; $display("FAIL step_load: got %0d want %0d", state_o[0], STEP); end
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) begin stall_i = 0; thread_sel_i = 0; end
      tick();
      n_checks++; if (state_o[0] !== want[i + 1]) begin n_fail++; $display("FAIL step_seq%0d: got %0d want %0d", i, state_o[0], want[i + 1]); end
    end
  endtask

  task automatic test_error();
    net_start_i = 1; net_tid_i = 1; tick();
    stall_i = 0; thread_sel_i = 1; instruction_i = kDONE; exception_i = 1; tick();
    n_checks++; if (state_o[1] !== ERR) begin n_fail++; $display("FAIL err_st1: got %0d want %0d", state_o[1], ERR); end
    n_checks++; if (err_valid_o !== 1'b1) begin n_fail++; $display("FAIL err_valid: got %b want 1", err_valid_o); end
    n_checks++; if (err_tid_o !== 1'b1) begin n_fail++; $display("FAIL err_tid: got %0d want 1", err_tid_o); end
    net_clear_i = 1; net_tid_i = 1; tick();
    n_checks++; if (state_o[1] !== IDLE) begin n_fail++; $display("FAIL clear_st1: got %0d want %0d", state_o[1], IDLE); end
    n_checks++; if (err_valid_o !== 1'b0) begin n_fail++; $display("FAIL clear_err_valid: got %b want 0", err_valid_o); end
  endtask

  task automatic test_two_errors();
    net_start_i = 1; net_tid_i = 0; tick();
    net_start_i = 1; net_tid_i = 1; tick();
    stall_i = 0; thread_sel_i = 0; exception_i = 1; tick();
    n_checks++; if (err_tid_o !== 1'b0) begin n_fail++; $display("FAIL two_err_first_tid: got %0d want 0", err_tid_o); end
    stall_i = 0; thread_sel_i = 1; exception_i = 1; tick();
    n_checks++; if (state_o[1] !== ERR) begin n_fail++; $display("FAIL two_err_st1: got %0d want %0d", state_o[1], ERR); end
    n_checks++; if (err_tid_o !== 1'b0) begin n_fail++; $display("FAIL two_err_tid_kept: got %0d want 0", err_tid_o); end
    net_clear_i = 1; net_tid_i = 0; tick();
    n_checks++; if (state_o[0] !== IDLE) begin n_fail++; $display("FAIL two_err_clear0: got %0d want %0d", state_o[0], IDLE); end
    n_checks++; if (err_valid_o !== 1'b1) begin n_fail++; $display("FAIL two_err_valid_held: got %b want 1", err_valid_o); end
    net_clear_i = 1; net_tid_i = 1; tick();
    n_checks++; if (err_valid_o !== 1'b0) begin n_fail++; $display("FAIL two_err_valid_cleared: got %b want 0", err_valid_o); end
    n_checks++; if (err_tid_o !== 1'b0) begin n_fail++; $display("FAIL two_err_tid_hold: got %0d want 0", err_tid_o); end
  endtask

  task automatic test_reset_mid_step();
    net_step_i = 1; net_tid_i = 0; net_step_cnt_i = 5; tick();
    n_checks++; if (state_o[0] !== STEP) begin n_fail++; $display("FAIL mid_reset_pre: got %0d want %0d", state_o[0], STEP); end
    #2 n_reset = 1'b0;
    #1;
    model_reset();
    n_checks++; if (state_o[0] !== IDLE) begin n_fail++; $display("FAIL mid_reset_async: got %0d want %0d", state_o[0], IDLE); end
    n_checks++; if (any_run_o !== 1'b0) begin n_fail++; $display("FAIL mid_reset_any_run: got %b want 0", any_run_o); end
    n_reset = 1'b1;
    stall_i = 0; thread_sel_i = 0; instruction_i = kDONE; tick();
    n_checks++; if (state_o[0] !== IDLE) begin n_fail++; $display("FAIL mid_reset_done: got %0d want %0d", state_o[0], IDLE); end
  endtask

  task automatic test_start_step_priority();
    net_start_i = 1; net_step_i = 1; net_tid_i = 0; net_step_cnt_i = 2; tick();
    n_checks++; if (state_o[0] !== RUN) begin n_fail++; $display("FAIL prio_start_wins: got %0d want %0d", state_o[0], RUN); end
    stall_i = 0; thread_sel_i = 0; instruction_i = kDONE; tick();
    net_step_i = 1; net_tid_i = 0; net_step_cnt_i = 0; tick();
    n_checks++; if (state_o[0] !== IDLE) begin n_fail++; $display("FAIL step_zero: got %0d want %0d", state_o[0], IDLE); end
    n_checks++; if (any_run_o !== 1'b0) begin n_fail++; $display("FAIL step_zero_any_run: got %b want 0", any_run_o); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      stall_i = $urandom_range(0, 9) < 3;
      thread_sel_i = TW'($urandom_range(0, 1));
      instruction_i = ($urandom_range(0, 9) < 3) ? kDONE : instruction_s'({8'($urandom_range(0, 254)), 24'($urandom)});
      exception_i = $urandom_range(0, 9) == 0;
      net_start_i = $urandom_range(0, 9) < 2;
      net_step_i = $urandom_range(0, 9) < 2;
      net_clear_i = $urandom_range(0, 9) < 3;
      net_tid_i = TW'($urandom_range(0, 1));
      net_step_cnt_i = STEP_W'($urandom_range(0, 4));
      tick();
      for (int t = 0; t < THREADS; t++) begin
        n_checks++; if (state_o[t] !== m_st[t]) begin n_fail++; $display("FAIL rand_st%0d cyc %0d: got %0d want %0d", t, n, state_o[t], m_st[t]); end
      end
      n_checks++; if (any_run_o !== m_run) begin n_fail++; $display("FAIL rand_any_run cyc %0d: got %b want %b", n, any_run_o, m_run); end
      n_checks++; if (err_valid_o !== m_ev) begin n_fail++; $display("FAIL rand_err_valid cyc %0d: got %b want %b", n, err_valid_o, m_ev); end
      n_checks++; if (err_tid_o !== TW'(m_etid)) begin n_fail++; $display("FAIL rand_err_tid cyc %0d: got %0d want %0d", n, err_tid_o, m_etid); end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_step();
    test_error();
    test_two_errors();
    test_reset_mid_step();
    test_start_step_priority();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
